// File: rtl/apb_req_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : apb_req_arbiter                                             |
// | Purpose  : Round-robin arbiter that shares one APB master port between |
// |            NUM_REQ local requesters and sequences SETUP/ACCESS phases. |
// |            Also drives the enable of the APB-domain clock gate.        |
// | Ports    : clk, reset_n          - clock, async active-low reset       |
// |            req/req_write/        - per-requester request, direction,  |
// |            req_addr/req_wdata      packed address and write data      |
// |            grant, done, err,     - owner, completion pulse, timeout   |
// |            rdata                   flag and read data                 |
// |            PSEL..PREADY          - APB master signals                 |
// |            clk_en                - clock-gate enable for APB domain   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module apb_req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 15,
  parameter int IDLE_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  output logic                      clk_en
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [7:0]         wait_cnt;
  logic [3:0]         hold_cnt;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int                 cand;
  logic               win_write;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  // Search offsets from NUM_REQ down to 1 so the smallest offset after the
  // pointer (the first requester after the last owner) is the final winner.
  // Offset NUM_REQ wraps back to the last owner itself, giving it the lowest
  // priority, which is what keeps a persistent requester from winning twice.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_write = req_write[win_idx];
    win_addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    win_wdata = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= IDX_W'(NUM_REQ - 1);
      owner    <= '0;
      wait_cnt <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      done     <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      clk_en   <= 1'b0;
    end else begin
      // Hold counter is reloaded every busy cycle and only counts down once
      // the bus is idle with nothing pending.
      if ((|req) || (state != IDLE)) begin
        clk_en   <= 1'b1;
        hold_cnt <= 4'(IDLE_HOLD);
      end else if (hold_cnt != 4'd0) begin
        clk_en   <= 1'b1;
        hold_cnt <= hold_cnt - 4'd1;
      end else begin
        clk_en   <= 1'b0;
      end

      case (state)
        IDLE: begin
          done    <= '0;
          err     <= 1'b0;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          if (win_found) begin
            grant  <= NUM_REQ'(1) << win_idx;
            owner  <= win_idx;
            PWRITE <= win_write;
            PADDR  <= win_addr;
            PWDATA <= win_wdata;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end

        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            done    <= grant;
            err     <= 1'b0;
            if (!PWRITE) rdata <= PRDATA;
            ptr     <= owner;
            grant   <= '0;
            state   <= IDLE;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th consecutive low sample: abort.
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            done    <= grant;
            err     <= 1'b1;
            rdata   <= '0;
            ptr     <= owner;
            grant   <= '0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
